// File: rtl/spectrum_bar_writer.sv
// spectrum_bar_writer: turns one frame of FFT bin magnitudes into a bar-graph
// image and writes it pixel-by-pixel into the SDRAM frame buffer over an
// Avalon-MM master write port.
module spectrum_bar_writer #(
    parameter int unsigned NUM_BINS  = 64,
    parameter int unsigned BAR_W     = 5,
    parameter int unsigned HEIGHT    = 240,
    parameter int unsigned MAG_W     = 16,
    parameter int unsigned MAG_SHIFT = 8,
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [MAG_W-1:0]  bin_data,
    input  logic              bin_valid,
    output logic              bin_ready,
    input  logic              frame_start,
    input  logic [15:0]       bar_color,
    input  logic [15:0]       bg_color,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_write,
    output logic [15:0]       m_writedata,
    input  logic              m_waitrequest,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned WIDTH = NUM_BINS * BAR_W;
    localparam int unsigned XW    = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;
    localparam int unsigned YW    = (HEIGHT > 1)   ? $clog2(HEIGHT)   : 1;
    localparam int unsigned HW    = $clog2(HEIGHT + 1);
    localparam int unsigned BW    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int unsigned SW    = (BAR_W > 1)    ? $clog2(BAR_W)    : 1;

    localparam logic [XW-1:0]     X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [SW-1:0]     S_LAST   = SW'(BAR_W - 1);
    localparam logic [BW-1:0]     B_LAST   = BW'(NUM_BINS - 1);
    localparam logic [HW-1:0]     H_MAX    = HW'(HEIGHT);
    localparam logic [MAG_W-1:0]  MAG_MAX  = MAG_W'(HEIGHT);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_ARMED,
        ST_DRAW
    } state_t;

    state_t state, state_next;

    logic [HW-1:0]     heights [NUM_BINS];
    logic [BW-1:0]     idx;
    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [SW-1:0]     sub_cnt;
    logic [BW-1:0]     bin_cnt;
    logic [ADDR_W-1:0] row_base;
    logic [15:0]       bar_q;
    logic [15:0]       bg_q;

    logic [MAG_W-1:0]  mag_shifted;
    logic [HW-1:0]     mag_height;
    logic [HW-1:0]     cur_height;
    logic [HW-1:0]     lit_threshold;
    logic              lit;
    logic              accept_bin;
    logic              accept_pix;

    // Saturate the scaled magnitude to the frame height and decide whether the current pixel is lit.
    always_comb begin
        mag_shifted   = bin_data >> MAG_SHIFT;
        mag_height    = (mag_shifted > MAG_MAX) ? H_MAX : HW'(mag_shifted);
        cur_height    = heights[bin_cnt];
        lit_threshold = H_MAX - cur_height;
        lit           = (HW'(y_cnt) >= lit_threshold);
        accept_bin    = bin_valid && bin_ready;
        accept_pix    = (state == ST_DRAW) && !m_waitrequest;
    end

    // State register.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and Avalon master outputs.
    always_comb begin
        state_next  = state;
        m_write     = 1'b0;
        busy        = 1'b0;
        m_address   = '0;
        m_writedata = '0;
        case (state)
            ST_LOAD: begin
                if (accept_bin && (idx == B_LAST)) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    state_next = ST_DRAW;
                end
            end
            ST_DRAW: begin
                m_write     = 1'b1;
                busy        = 1'b1;
                m_address   = BASE + row_base + ADDR_W'(x_cnt);
                m_writedata = lit ? bar_q : bg_q;
                if (!m_waitrequest && (x_cnt == X_LAST) && (y_cnt == Y_LAST)) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // bin_ready is registered so it stays low on the reset cycle and rises one cycle later.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            bin_ready  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            bin_ready  <= (state_next == ST_LOAD);
            frame_done <= (state == ST_DRAW) && (state_next == ST_LOAD);
        end
    end

    // Bin capture, colour latch and raster counters (row base accumulates WIDTH per row).
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            idx      <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            sub_cnt  <= '0;
            bin_cnt  <= '0;
            row_base <= '0;
            bar_q    <= '0;
            bg_q     <= '0;
            for (int unsigned i = 0; i < NUM_BINS; i++) begin
                heights[i] <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept_bin) begin
                        heights[idx] <= mag_height;
                        idx          <= (idx == B_LAST) ? '0 : idx + 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (frame_start) begin
                        bar_q    <= bar_color;
                        bg_q     <= bg_color;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        sub_cnt  <= '0;
                        bin_cnt  <= '0;
                        row_base <= '0;
                    end
                end
                ST_DRAW: begin
                    if (accept_pix) begin
                        if (x_cnt == X_LAST) begin
                            x_cnt    <= '0;
                            sub_cnt  <= '0;
                            bin_cnt  <= '0;
                            y_cnt    <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
                            row_base <= row_base + ROW_STEP;
                            if (y_cnt == Y_LAST) begin
                                idx <= '0;
                            end
                        end else begin
                            x_cnt <= x_cnt + 1'b1;
                            if (sub_cnt == S_LAST) begin
                                sub_cnt <= '0;
                                bin_cnt <= bin_cnt + 1'b1;
                            end else begin
                                sub_cnt <= sub_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spectrum_bar_writer.sv
// tb_spectrum_bar_writer: directed and randomized frames against a bar-graph
// reference model computed from bin magnitudes with plain arithmetic.
module tb_spectrum_bar_writer;

    localparam int unsigned NB   = 4;
    localparam int unsigned BARW = 2;
    localparam int unsigned H    = 4;
    localparam int unsigned SH   = 0;
    localparam int unsigned BASE = 32'h100;
    localparam int unsigned W    = NB * BARW;
    localparam int unsigned NPIX = W * H;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [15:0] bin_data;
    logic        bin_valid;
    logic        bin_ready;
    logic        frame_start;
    logic [15:0] bar_color;
    logic [15:0] bg_color;
    logic [24:0] m_address;
    logic        m_write;
    logic [15:0] m_writedata;
    logic        m_waitrequest;
    logic        busy;
    logic        frame_done;

    int          tests = 0;
    int          fails = 0;
    int unsigned mags [NB];

    spectrum_bar_writer #(
        .NUM_BINS  (NB),
        .BAR_W     (BARW),
        .HEIGHT    (H),
        .MAG_W     (16),
        .MAG_SHIFT (SH),
        .ADDR_W    (25),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bin_data      (bin_data),
        .bin_valid     (bin_valid),
        .bin_ready     (bin_ready),
        .frame_start   (frame_start),
        .bar_color     (bar_color),
        .bg_color      (bg_color),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_height(input int unsigned m);
        int unsigned s;
        s = m >> SH;
        return (s > H) ? H : s;
    endfunction

    function automatic logic [15:0] model_pix(input int unsigned px, input int unsigned py,
                                              input logic [15:0] bar, input logic [15:0] bg);
        int unsigned h;
        h = model_height(mags[px / BARW]);
        return (py + h >= H) ? bar : bg;
    endfunction

    task automatic load_range(input int unsigned first, input int unsigned last, input int unsigned gap_max);
        for (int unsigned i = first; i <= last; i++) begin
            int unsigned gap;
            int unsigned n;
            gap       = $urandom_range(gap_max, 0);
            bin_valid = 1'b0;
            repeat (gap) tick();
            bin_valid = 1'b1;
            bin_data  = 16'(mags[i]);
            n = 0;
            while (!bin_ready && n < 50) begin
                tick();
                n++;
            end
            if (!bin_ready) check("load_timeout", 32'(bin_ready), 32'(1));
            tick();
        end
        bin_valid = 1'b0;
        bin_data  = '0;
    endtask

    task automatic draw_frame(input logic [15:0] exp_bar, input logic [15:0] exp_bg, input int mode,
                              input int chg_at, input logic [15:0] chg_bar, input int abort_at,
                              output int cyc);
        int unsigned acc;
        logic        stalled;
        logic        wr;
        logic        changed;
        logic [31:0] paddr;
        logic [31:0] pdata;
        acc     = 0;
        cyc     = 0;
        stalled = 1'b0;
        changed = 1'b0;
        paddr   = '0;
        pdata   = '0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        while (acc < NPIX && cyc < 400) begin
            if (abort_at >= 0 && acc == 32'(abort_at)) begin
                m_waitrequest = 1'b1;
                frame_start   = 1'b0;
                return;
            end
            check("draw_write", 32'(m_write), 32'(1));
            check("draw_busy", 32'(busy), 32'(1));
            check("draw_done_low", 32'(frame_done), 32'(0));
            if (stalled) begin
                check("stall_addr", 32'(m_address), paddr);
                check("stall_data", 32'(m_writedata), pdata);
            end
            case (mode)
                1:       wr = (cyc % 2 == 0);
                2:       wr = ($urandom_range(2, 0) == 0);
                default: wr = 1'b0;
            endcase
            if (mode == 2) frame_start = 1'($urandom_range(1, 0));
            m_waitrequest = wr;
            if (!wr) begin
                check("pix_addr", 32'(m_address), BASE + acc);
                check("pix_data", 32'(m_writedata), 32'(model_pix(acc % W, acc / W, exp_bar, exp_bg)));
                acc++;
            end
            paddr   = 32'(m_address);
            pdata   = 32'(m_writedata);
            stalled = wr;
            if (!changed && chg_at >= 0 && acc == 32'(chg_at)) begin
                bar_color = chg_bar;
                bg_color  = ~bg_color;
                changed   = 1'b1;
            end
            tick();
            cyc++;
        end
        frame_start   = 1'b0;
        m_waitrequest = 1'b0;
        check("frame_count", acc, NPIX);
        check("done_pulse", 32'(frame_done), 32'(1));
        check("done_write_low", 32'(m_write), 32'(0));
        check("done_busy_low", 32'(busy), 32'(0));
        tick();
        check("done_once", 32'(frame_done), 32'(0));
        check("ready_back", 32'(bin_ready), 32'(1));
    endtask

    initial begin
        int          cyc;
        logic [15:0] eb;
        logic [15:0] eg;

        reset_reset_n = 1'b0;
        bin_data      = '0;
        bin_valid     = 1'b0;
        frame_start   = 1'b0;
        bar_color     = 16'hF800;
        bg_color      = 16'h001F;
        m_waitrequest = 1'b0;
        tick();
        tick();
        check("rst_bin_ready", 32'(bin_ready), 32'(0));
        check("rst_m_write", 32'(m_write), 32'(0));
        check("rst_m_address", 32'(m_address), 32'(0));
        check("rst_m_writedata", 32'(m_writedata), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        reset_reset_n = 1'b1;
        tick();
        check("rst_ready_rise", 32'(bin_ready), 32'(1));

        // 1: basic frame, no stalls
        mags = '{0, 1, 4, 9};
        load_range(0, NB - 1, 0);
        check("armed_ready_low", 32'(bin_ready), 32'(0));
        check("armed_no_write", 32'(m_write), 32'(0));
        tick();
        check("armed_idle", 32'(busy), 32'(0));
        draw_frame(16'hF800, 16'h001F, 0, -1, 16'h0000, -1, cyc);
        check("one_per_cycle", 32'(cyc), NPIX);

        // 2: waitrequest on every other cycle
        load_range(0, NB - 1, 2);
        draw_frame(16'hF800, 16'h001F, 1, -1, 16'h0000, -1, cyc);
        check("alt_stall_cycles", 32'(cyc), 2 * NPIX);

        // 3: frame_start before all bins are loaded is ignored
        load_range(0, 1, 3);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) begin
            check("early_start_no_write", 32'(m_write), 32'(0));
            check("early_start_not_busy", 32'(busy), 32'(0));
            check("early_start_loading", 32'(bin_ready), 32'(1));
            tick();
        end
        load_range(2, NB - 1, 3);
        check("late_armed", 32'(bin_ready), 32'(0));
        draw_frame(16'hF800, 16'h001F, 0, -1, 16'h0000, -1, cyc);

        // 4: colour change mid-frame only affects the next frame
        bar_color = 16'hF800;
        load_range(0, NB - 1, 1);
        draw_frame(16'hF800, 16'h001F, 0, 10, 16'h07E0, -1, cyc);
        eg = bg_color;
        load_range(0, NB - 1, 1);
        draw_frame(16'h07E0, eg, 0, -1, 16'h0000, -1, cyc);

        // 5: reset during pixel 10 with waitrequest held
        load_range(0, NB - 1, 0);
        draw_frame(16'h07E0, eg, 0, -1, 16'h0000, 10, cyc);
        check("abort_addr", 32'(m_address), BASE + 10);
        tick();
        check("abort_held_addr", 32'(m_address), BASE + 10);
        check("abort_held_write", 32'(m_write), 32'(1));
        reset_reset_n = 1'b0;
        tick();
        check("midrst_write", 32'(m_write), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_ready", 32'(bin_ready), 32'(0));
        check("midrst_done", 32'(frame_done), 32'(0));
        reset_reset_n = 1'b1;
        m_waitrequest = 1'b0;
        tick();
        check("postrst_ready", 32'(bin_ready), 32'(1));
        check("postrst_done", 32'(frame_done), 32'(0));
        check("postrst_write", 32'(m_write), 32'(0));
        tick();
        check("postrst_done2", 32'(frame_done), 32'(0));

        // 6: saturating magnitude, random stalls
        mags = '{32'hFFFF, 0, 5, 3};
        bar_color = 16'h1234;
        bg_color  = 16'h0000;
        load_range(0, NB - 1, 2);
        draw_frame(16'h1234, 16'h0000, 2, -1, 16'h0000, -1, cyc);

        // 7: randomized frames
        for (int k = 0; k < 3; k++) begin
            for (int unsigned i = 0; i < NB; i++) mags[i] = $urandom_range(6, 0);
            eb = 16'($urandom);
            eg = 16'($urandom);
            bar_color = eb;
            bg_color  = eg;
            load_range(0, NB - 1, 3);
            draw_frame(eb, eg, 2, -1, 16'h0000, -1, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spectrum_bar_writer.md
Name: spectrum_bar_writer

Overview:
- Writer side of the VGA frame buffer: converts one frame of FFT bin magnitudes into a bar-graph image.
- Writes the image pixel-by-pixel into the SDRAM frame buffer over an Avalon-MM master write port. The pixel buffer DMA reads that buffer out to vga_vga_*.
- Sits between the FFT magnitude stream and the SDRAM arbiter inside the vga_system clock domain.

Parameters:
- NUM_BINS, 64: bins per frame; one bar per bin.
- BAR_W, 5: pixel columns per bar. WIDTH = NUM_BINS*BAR_W.
- HEIGHT, 240: rows in the frame buffer.
- MAG_W, 16: bin magnitude width.
- MAG_SHIFT, 8: right shift applied to a magnitude to get bar height in pixels.
- ADDR_W, 25: Avalon address width, in pixel (16-bit word) units.
- BASE_ADDR, 0: word address of pixel (0,0).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  reset, synchronous, active-low.
- bin_data  in  MAG_W  bin magnitude, bin 0 first.
- bin_valid  in  1  bin_data valid.
- bin_ready  out  1  block accepts a bin this cycle.
- frame_start  in  1  one-cycle pulse (vsync-derived) that starts drawing.
- bar_color  in  16  RGB565 colour for lit pixels.
- bg_color  in  16  RGB565 colour for background pixels.
- m_address  out  ADDR_W  Avalon word address.
- m_write  out  1  Avalon write request.
- m_writedata  out  16  pixel data.
- m_waitrequest  in  1  Avalon stall.
- busy  out  1  high while in DRAW.
- frame_done  out  1  one-cycle pulse after the last pixel write is accepted.

Behaviour:
- Reset: when reset_reset_n=0 at a clock edge, the block enters LOAD.
  - Reset values: bin_ready=0, m_write=0, m_address=0, m_writedata=0, busy=0, frame_done=0.
  - All counters clear.
  - bin_ready rises on the first cycle after reset deasserts.
- LOAD:
  - bin_ready=1.
  - A bin is accepted when bin_valid & bin_ready.
  - Stored height = min(bin_data >> MAG_SHIFT, HEIGHT), written to entry idx; then idx increments.
  - On acceptance of bin NUM_BINS-1: go to ARMED and drop bin_ready on the next cycle.
  - frame_start is ignored in LOAD.
- ARMED:
  - bin_ready=0; waits for frame_start.
  - On frame_start: latch bar_color and bg_color, clear x, y and the row-base accumulator, then enter DRAW.
  - The first write is presented on the next cycle.
- DRAW:
  - m_write=1, busy=1.
  - m_address = BASE_ADDR + y*WIDTH + x. The y*WIDTH term comes from a row-base accumulator that adds WIDTH per row; no multiplier.
  - Bar index comes from a bin counter plus a sub-column counter (0..BAR_W-1); no divider.
  - Pixel is lit iff y >= HEIGHT - h[bin]. Lit -> m_writedata = latched bar_color; otherwise latched bg_color.
  - While m_waitrequest=1, address, data and write are held stable.
  - A cycle with m_waitrequest=0 accepts the write and advances x.
  - At x=WIDTH-1, x wraps to 0 and y increments.
  - Acceptance of pixel (WIDTH-1, HEIGHT-1): m_write=0 and frame_done=1 on the next cycle, return to LOAD, idx=0.
- Throughput: 1 pixel/cycle with no stalls. A frame takes WIDTH*HEIGHT cycles plus stall cycles.
- Height boundaries:
  - h=0: whole column background.
  - h=HEIGHT: whole column lit.
  - Magnitudes saturate; no wrap.
- frame_start during DRAW or LOAD: ignored, no restart.
- bar_color or bg_color changing during DRAW: no effect until the next frame.
- Reset mid-DRAW: m_write drops at the next edge and the partial frame is abandoned. The SDRAM arbiter tolerates this only at reset.

Test Plan:
Bench parameters: NUM_BINS=4, BAR_W=2, HEIGHT=4, MAG_SHIFT=0, BASE_ADDR=0x100.
1. Reset then load bins {0,1,4,9}, pulse frame_start, no stalls.
   - Expect 32 writes at addresses 0x100..0x11F in order, one per cycle.
   - Row 3 columns: bin0 bg, bins1..3 bar. Rows 0..2: bins 2,3 bar only.
   - frame_done pulses once, 1 cycle after the last write.
   - bin_ready returns to 1.
2. Same load, m_waitrequest high on every other cycle.
   - Address and data stable across each stall; no duplicate or skipped address.
   - Still exactly 32 accepted writes.
3. Hold bin_valid=0 for random cycles during LOAD, and pulse frame_start before all 4 bins arrive.
   - frame_start ignored; no writes.
   - A later frame_start after the 4th bin starts drawing.
4. Change bar_color from 0xF800 to 0x07E0 mid-DRAW.
   - All lit pixels in the frame are 0xF800.
   - The next frame uses 0x07E0.
5. Assert reset_reset_n=0 for 1 cycle during pixel 10 with waitrequest held.
   - m_write=0, busy=0 and bin_ready=0 on the reset edge.
   - bin_ready=1 on the next cycle; no frame_done.
6. Bin magnitude 0xFFFF with MAG_SHIFT=0.
   - Height saturates to 4; the full column is lit.
